// File: rtl/tx_parity_serial.sv
// tx_parity_serial: UART-style serialiser sending start, 8 data bits LSB first, odd parity and stop bits
module tx_parity_serial #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       out,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d, out_q, out_d;
  logic        bit_end, frame_end, accept;
  assign bit_end   = cnt_q == LAST_CNT;
  assign frame_end = state_q == STOP && bit_end && idx_q == LAST_STOP;
  assign tx_ready  = state_q == IDLE || frame_end;
  assign accept    = tx_valid && tx_ready;
  assign busy      = state_q != IDLE;
  assign done      = frame_end;
  assign out       = out_q;
  // next state; the line value is derived from the next state so out stays a pure register
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    case (state_q)
      IDLE:   cnt_d = 16'd0;
      START:  if (bit_end) begin state_d = DATA; idx_d = 3'd0; end
      DATA:   if (bit_end) begin
                if (idx_q == 3'd7) state_d = PARITY;
                else begin idx_d = idx_q + 3'd1; sh_d = sh_q >> 1; end
              end
      PARITY: if (bit_end) begin state_d = STOP; idx_d = 3'd0; end
      STOP:   if (bit_end) begin
                if (idx_q != LAST_STOP) idx_d = idx_q + 3'd1;
                else state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = START;
      cnt_d   = 16'd0;
      idx_d   = 3'd0;
      sh_d    = tx_data;
      par_d   = ~^tx_data;
    end
    out_d = state_d == START  ? 1'b0 :
            state_d == DATA   ? sh_d[0] :
            state_d == PARITY ? par_d : 1'b1;
  end
  // state register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: doc/tx_parity_serial.md
TX_PARITY_SERIAL -- requirements
Module: tx_parity_serial

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1, meaning the number of clk cycles each serial bit is held on out (legal range 1..65535).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits per frame (legal values 1 or 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send, LSB first.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port out, output, 1 bit: the serial line, idling high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-011 The frame format SHALL be 1 start bit (0), then data bits d0..d7 LSB first, then 1 odd-parity bit, then STOP_BITS stop bits (1).
REQ-012 The parity bit SHALL equal the inverse of the XOR-reduction of the captured byte, so that the 9 bits (data plus parity) contain an odd number of 1s.
REQ-013 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 State transitions SHALL be as follows:
- IDLE->START on an accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY after 8 bit periods.
- PARITY->STOP after 1 bit period.
- STOP->IDLE after STOP_BITS bit periods, or STOP->START if an accept occurs in the final cycle.
REQ-015 An accept SHALL be tx_valid && tx_ready sampled at a rising edge; tx_data SHALL be captured into an internal shift register on that edge, so later changes to tx_data do not affect the frame.
REQ-016 tx_ready SHALL be 1 in IDLE and in the final clk cycle of the last stop bit, and 0 otherwise.
REQ-017 out SHALL be registered, and the start bit SHALL appear on out in the cycle immediately after the accept edge.
REQ-018 Each bit SHALL be held on out for exactly CLKS_PER_BIT consecutive cycles, timed by an internal bit-period counter (16 bits) that resets at every bit boundary.
REQ-019 A DATA bit index counter (3 bits) SHALL count 0..7 and SHALL not wrap into a ninth data bit.
REQ-020 Back-to-back frames SHALL have no idle gap: when accepted in the final stop cycle, the next start bit immediately follows the last stop bit.
REQ-021 out SHALL be 1 whenever the state is IDLE or STOP.
REQ-022 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-023 done SHALL pulse high for exactly one cycle, coincident with the final clk cycle of the last stop bit, once per frame, including in back-to-back operation.
REQ-024 tx_valid asserted while tx_ready=0 SHALL be ignored, with no capture and no effect on the current frame; the source SHALL hold it until accepted.
REQ-025 Total frame length SHALL be (10+STOP_BITS)*CLKS_PER_BIT cycles, from the first start-bit cycle through the last stop-bit cycle.

Reset
REQ-026 While reset=1 the following SHALL hold at the next edge:
- state=IDLE, counters=0, shift register=0.
- out=1, busy=0, done=0.
- tx_ready=1 after reset deasserts.
REQ-027 Reset asserted mid-frame SHALL abort the frame: out returns to 1 at the next edge, no done pulse is produced, and no partial frame resumes.
REQ-028 Reset SHALL take priority over an accept in the same cycle.

Verification
REQ-029 CLKS_PER_BIT=1, STOP_BITS=1, accept 0x4B -> out for 11 cycles = 0,1,1,0,1,0,0,1,0,1,1; done pulses on the 11th cycle; busy high for 11 cycles.
REQ-030 Accept 0x07 (three 1s) -> parity bit 0; accept 0xFF -> parity bit 1; accept 0x00 -> parity bit 1.
REQ-031 Back-to-back: tx_valid held high with 0x4B then 0xA5 -> 22 contiguous frame cycles, no idle 1 between the frames, two done pulses 11 cycles apart, 0xA5 parity bit 1.
REQ-032 CLKS_PER_BIT=4, STOP_BITS=2, accept 0x81 -> each bit held 4 cycles; frame 48 cycles; out = 0,1,0,0,0,0,0,0,1,1,1,1 per bit period.
REQ-033 Reset asserted in the 5th data bit of a frame -> out=1, busy=0, tx_ready=1 on the following cycles, no done pulse; a new accept of 0x4B afterwards produces the exact frame in REQ-029.
REQ-034 tx_valid pulsed while busy, with tx_data changed mid-frame -> in-flight frame bits unchanged and no extra frame sent.
